// File: rtl/digit_overlay_mixer.sv
// Composites up to eight BCD glyph channels over a background pixel stream.
// Fixed 3-clock pipeline: hit/address select, glyph ROM read, colour mux.
module digit_overlay_mixer #(
    parameter int                        NUM_DIGITS   = 4,
    parameter logic [9*NUM_DIGITS-1:0]   X_POS_LIST   = {9'd290, 9'd280, 9'd80, 9'd70},
    parameter int                        Y_POS        = 3,
    parameter int                        DIGIT_W      = 10,
    parameter int                        DIGIT_H      = 12,
    parameter int                        COLOR_W      = 3,
    parameter logic [COLOR_W-1:0]        KEY_COLOR    = '0,
    parameter logic [NUM_DIGITS-1:0]     LEAD_MASK    = 4'b0101,
    parameter int                        BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8:0]                xvga,
    input  logic [7:0]                yvga,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic                      overlay_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      suppress_lz,
    input  logic [COLOR_W-1:0]        bg_color,
    output logic [11:0]               glyph_addr,
    input  logic [COLOR_W-1:0]        glyph_pixel,
    output logic [COLOR_W-1:0]        color
);

    localparam int              FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [8:0]      Y_LO     = 9'(Y_POS);
    localparam logic [8:0]      Y_HI     = 9'(Y_POS + DIGIT_H);
    localparam logic [3:0]      ROW_BASE = 4'(Y_POS);

    // Stage-0 per-channel decode
    logic [NUM_DIGITS-1:0] ch_hit;
    logic [3:0]            ch_col [NUM_DIGITS];
    logic                  in_y;
    logic                  blink_phase_q;

    assign in_y = ({1'b0, yvga} >= Y_LO) && ({1'b0, yvga} < Y_HI);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_ch
        localparam logic [9:0] X_LO = {1'b0, X_POS_LIST[9*g +: 9]};
        localparam logic [9:0] X_HI = X_LO + 10'(DIGIT_W);

        logic [3:0] digit;
        logic       in_x;
        logic       visible;

        assign digit   = digits[4*g +: 4];
        assign in_x    = ({1'b0, xvga} >= X_LO) && ({1'b0, xvga} < X_HI);
        assign visible = (digit <= 4'd9)
                      && !(blink_mask[g] && blink_phase_q)
                      && !(suppress_lz && LEAD_MASK[g] && (digit == 4'd0));
        assign ch_hit[g] = overlay_en && in_x && in_y && visible;
        // Column offset only needs the low nibble of the difference.
        assign ch_col[g] = xvga[3:0] - X_LO[3:0];
    end

    // Lowest-index channel wins: scan high to low so the last write is the winner.
    logic       win_hit;
    logic [3:0] win_digit;
    logic [3:0] win_col;

    always_comb begin
        win_hit   = 1'b0;
        win_digit = 4'd0;
        win_col   = 4'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (ch_hit[i]) begin
                win_hit   = 1'b1;
                win_digit = digits[4*i +: 4];
                win_col   = ch_col[i];
            end
        end
    end

    // Frame tick and blink phase
    logic            prev_origin_q, prev_origin_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_phase_d;
    logic            origin;
    logic            frame_tick;

    assign origin     = (xvga == 9'd0) && (yvga == 8'd0);
    assign frame_tick = origin && !prev_origin_q;

    always_comb begin
        prev_origin_d = origin;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Pixel pipeline
    logic               hit_q, hit_d;
    logic               hit_qq, hit_dd;
    logic [11:0]        glyph_addr_q, glyph_addr_d;
    logic [COLOR_W-1:0] bg_q, bg_d;
    logic [COLOR_W-1:0] color_q, color_d;

    always_comb begin
        hit_d        = win_hit;
        glyph_addr_d = glyph_addr_q;
        if (win_hit) begin
            glyph_addr_d = {win_digit, yvga[3:0] - ROW_BASE, win_col};
        end
        hit_dd  = hit_q;
        bg_d    = bg_color;
        // Glyph ROM data lines up with hit_qq/bg_q in this window.
        color_d = (hit_qq && (glyph_pixel != KEY_COLOR)) ? glyph_pixel : bg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_origin_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            hit_q         <= 1'b0;
            hit_qq        <= 1'b0;
            glyph_addr_q  <= 12'd0;
            bg_q          <= '0;
            color_q       <= '0;
        end else begin
            prev_origin_q <= prev_origin_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            hit_q         <= hit_d;
            hit_qq        <= hit_dd;
            glyph_addr_q  <= glyph_addr_d;
            bg_q          <= bg_d;
            color_q       <= color_d;
        end
    end

    assign glyph_addr = glyph_addr_q;
    assign color      = color_q;

endmodule

// File: tb/tb_digit_overlay_mixer.sv
// Directed bench for digit_overlay_mixer: channel 1 moved to x=75 so it overlaps channel 0,
// blink half-period shortened to 2 frames.
module tb_digit_overlay_mixer;

    localparam logic [8:0] IDLE_X = 9'd400;
    localparam logic [7:0] IDLE_Y = 8'd200;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  xvga;
    logic [7:0]  yvga;
    logic [15:0] digits;
    logic        overlay_en;
    logic [3:0]  blink_mask;
    logic        suppress_lz;
    logic [2:0]  bg_color;
    logic [11:0] glyph_addr;
    logic [2:0]  glyph_pixel;
    logic [2:0]  color;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digit_overlay_mixer #(
        .NUM_DIGITS  (4),
        .X_POS_LIST  ({9'd290, 9'd280, 9'd75, 9'd70}),
        .Y_POS       (3),
        .DIGIT_W     (10),
        .DIGIT_H     (12),
        .COLOR_W     (3),
        .KEY_COLOR   (3'b000),
        .LEAD_MASK   (4'b0101),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xvga       (xvga),
        .yvga       (yvga),
        .digits     (digits),
        .overlay_en (overlay_en),
        .blink_mask (blink_mask),
        .suppress_lz(suppress_lz),
        .bg_color   (bg_color),
        .glyph_addr (glyph_addr),
        .glyph_pixel(glyph_pixel),
        .color      (color)
    );

    // One pixel through the pipeline, called at a negedge. bg arrives one cycle after
    // the coordinate, glyph data two cycles after; other cycles carry inverted junk.
    task automatic run_pixel(input logic [8:0] x, input logic [7:0] y, input logic [2:0] bg,
                             input logic [2:0] gp, output logic [11:0] addr,
                             output logic hq, output logic [2:0] col);
        xvga = x; yvga = y; bg_color = ~bg; glyph_pixel = ~gp;
        @(negedge clk);
        addr = glyph_addr; hq = dut.hit_q;
        xvga = IDLE_X; yvga = IDLE_Y; bg_color = bg;
        @(negedge clk);
        bg_color = ~bg; glyph_pixel = gp;
        @(negedge clk);
        col = color;
    endtask

    task automatic frame_tick(input int hold);
        xvga = 9'd0; yvga = 8'd0;
        repeat (hold) @(negedge clk);
        xvga = IDLE_X; yvga = IDLE_Y;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] a; logic h; logic [2:0] c;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            xvga = 9'($urandom_range(0, 511)); yvga = 8'($urandom_range(0, 255));
            digits = 16'($urandom_range(0, 65535)); overlay_en = 1'($urandom_range(0, 1));
            bg_color = 3'($urandom_range(0, 7)); glyph_pixel = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        total++; if (color !== 3'b000) begin bad++; $display("FAIL reset_color got=%b exp=000", color); end
        total++; if (glyph_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", glyph_addr); end
        total++; if (dut.frame_cnt_q !== 1'b0 || dut.blink_phase_q !== 1'b0) begin
            bad++; $display("FAIL reset_frame got=%b/%b exp=0/0", dut.frame_cnt_q, dut.blink_phase_q); end
        rst = 1'b0;
        digits = 16'h1234; overlay_en = 1'b1; blink_mask = 4'b0000; suppress_lz = 1'b0;
        run_pixel(9'd0, 8'd0, 3'b010, 3'b111, a, h, c);
        total++; if (c !== 3'b010) begin bad++; $display("FAIL reset_first_color got=%b exp=010", c); end
        total++; if (h !== 1'b0) begin bad++; $display("FAIL reset_first_hit got=%b exp=0", h); end
        // Reset landing mid-pipeline must flush everything asynchronously.
        xvga = 9'd73; yvga = 8'd5; bg_color = 3'b101; glyph_pixel = 3'b111;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (dut.hit_q !== 1'b0 || dut.hit_qq !== 1'b0) begin
            bad++; $display("FAIL reset_mid_flags got=%b%b exp=00", dut.hit_q, dut.hit_qq); end
        total++; if (glyph_addr !== 12'h000 || color !== 3'b000) begin
            bad++; $display("FAIL reset_mid_out got=%h/%b exp=000/000", glyph_addr, color); end
        @(negedge clk);
        rst = 1'b0;
        xvga = IDLE_X; yvga = IDLE_Y;
        @(negedge clk);
    endtask

    task automatic test_single_hit();
        logic [11:0] a; logic h; logic [2:0] c;
        digits = 16'h1234; overlay_en = 1'b1; blink_mask = 4'b0000; suppress_lz = 1'b0;
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (a !== 12'h423) begin bad++; $display("FAIL hit_addr got=%h exp=423", a); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL hit_flag got=%b exp=1", h); end
        total++; if (c !== 3'b111) begin bad++; $display("FAIL hit_color got=%b exp=111", c); end
        run_pixel(9'd73, 8'd5, 3'b010, 3'b000, a, h, c);
        total++; if (c !== 3'b010) begin bad++; $display("FAIL hit_key got=%b exp=010", c); end
        run_pixel(9'd70, 8'd3, 3'b001, 3'b110, a, h, c);
        total++; if (a !== 12'h400 || c !== 3'b110) begin
            bad++; $display("FAIL hit_topleft got=%h/%b exp=400/110", a, c); end
        run_pixel(9'd299, 8'd14, 3'b001, 3'b101, a, h, c);
        total++; if (a !== 12'h1B9 || c !== 3'b101) begin
            bad++; $display("FAIL hit_botright got=%h/%b exp=1b9/101", a, c); end
        run_pixel(9'd300, 8'd14, 3'b011, 3'b101, a, h, c);
        total++; if (a !== 12'h1B9 || h !== 1'b0 || c !== 3'b011) begin
            bad++; $display("FAIL miss_right got=%h/%b/%b exp=1b9/0/011", a, h, c); end
        run_pixel(9'd295, 8'd15, 3'b100, 3'b101, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b100) begin
            bad++; $display("FAIL miss_below got=%b/%b exp=0/100", h, c); end
        run_pixel(9'd69, 8'd5, 3'b110, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b110) begin
            bad++; $display("FAIL miss_left got=%b/%b exp=0/110", h, c); end
        run_pixel(9'd73, 8'd2, 3'b101, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b101) begin
            bad++; $display("FAIL miss_above got=%b/%b exp=0/101", h, c); end
    endtask

    task automatic test_priority();
        logic [11:0] a; logic h; logic [2:0] c;
        digits = 16'h1234;
        run_pixel(9'd76, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (a !== 12'h426) begin bad++; $display("FAIL prio_ch0 got=%h exp=426", a); end
        digits = 16'h123A;
        run_pixel(9'd76, 8'd5, 3'b010, 3'b011, a, h, c);
        total++; if (a !== 12'h321 || c !== 3'b011) begin
            bad++; $display("FAIL prio_ch1 got=%h/%b exp=321/011", a, c); end
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b010) begin
            bad++; $display("FAIL invalid_digit got=%b/%b exp=0/010", h, c); end
        digits = 16'h1234;
    endtask

    task automatic test_leading_zero();
        logic [11:0] a; logic h; logic [2:0] c;
        digits = 16'h1230; suppress_lz = 1'b1;
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b010) begin
            bad++; $display("FAIL lz_suppressed got=%b/%b exp=0/010", h, c); end
        run_pixel(9'd76, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (a !== 12'h321) begin bad++; $display("FAIL lz_fallthrough got=%h exp=321", a); end
        digits = 16'h1200;
        run_pixel(9'd82, 8'd5, 3'b010, 3'b101, a, h, c);
        total++; if (a !== 12'h027 || c !== 3'b101) begin
            bad++; $display("FAIL lz_unmasked got=%h/%b exp=027/101", a, c); end
        digits = 16'h1230; suppress_lz = 1'b0;
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (a !== 12'h023 || c !== 3'b111) begin
            bad++; $display("FAIL lz_off got=%h/%b exp=023/111", a, c); end
        digits = 16'h1234;
    endtask

    task automatic test_blink();
        logic [11:0] a; logic h; logic [2:0] c;
        pulse_reset();
        digits = 16'h1234; blink_mask = 4'b0001; suppress_lz = 1'b0; overlay_en = 1'b1;
        frame_tick(1);
        total++; if (dut.frame_cnt_q !== 1'b1 || dut.blink_phase_q !== 1'b0) begin
            bad++; $display("FAIL blink_tick1 got=%b/%b exp=1/0", dut.frame_cnt_q, dut.blink_phase_q); end
        frame_tick(3);
        total++; if (dut.frame_cnt_q !== 1'b0 || dut.blink_phase_q !== 1'b1) begin
            bad++; $display("FAIL blink_tick2 got=%b/%b exp=0/1", dut.frame_cnt_q, dut.blink_phase_q); end
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b010) begin
            bad++; $display("FAIL blink_hidden got=%b/%b exp=0/010", h, c); end
        run_pixel(9'd82, 8'd5, 3'b011, 3'b101, a, h, c);
        total++; if (a !== 12'h327 || c !== 3'b101) begin
            bad++; $display("FAIL blink_other got=%h/%b exp=327/101", a, c); end
        blink_mask = 4'b0000;
        run_pixel(9'd73, 8'd5, 3'b010, 3'b110, a, h, c);
        total++; if (c !== 3'b110) begin bad++; $display("FAIL blink_mask_off got=%b exp=110", c); end
        blink_mask = 4'b0001;
        frame_tick(1);
        frame_tick(2);
        total++; if (dut.frame_cnt_q !== 1'b0 || dut.blink_phase_q !== 1'b0) begin
            bad++; $display("FAIL blink_tick4 got=%b/%b exp=0/0", dut.frame_cnt_q, dut.blink_phase_q); end
        run_pixel(9'd73, 8'd5, 3'b010, 3'b111, a, h, c);
        total++; if (a !== 12'h423 || c !== 3'b111) begin
            bad++; $display("FAIL blink_visible got=%h/%b exp=423/111", a, c); end
        blink_mask = 4'b0000;
    endtask

    task automatic test_disabled();
        logic [11:0] a; logic h; logic [2:0] c;
        overlay_en = 1'b0;
        run_pixel(9'd295, 8'd10, 3'b100, 3'b111, a, h, c);
        total++; if (h !== 1'b0 || c !== 3'b100) begin
            bad++; $display("FAIL disabled got=%b/%b exp=0/100", h, c); end
        overlay_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [8:0] px [4];
        logic [7:0] py [4];
        logic [2:0] pbg [4];
        logic [2:0] pgp [4];
        logic [2:0] pexp [4];
        px = '{9'd73, 9'd200, 9'd82, 9'd295};
        py = '{8'd5, 8'd100, 8'd5, 8'd10};
        pbg = '{3'b010, 3'b011, 3'b100, 3'b001};
        pgp = '{3'b111, 3'b101, 3'b000, 3'b110};
        pexp = '{3'b111, 3'b011, 3'b100, 3'b110};
        digits = 16'h1234;
        for (int k = 0; k < 7; k++) begin
            if (k >= 3) begin
                total++; if (color !== pexp[k-3]) begin
                    bad++; $display("FAIL stream_%0d got=%b exp=%b", k - 3, color, pexp[k-3]); end
            end
            xvga = (k < 4) ? px[k] : IDLE_X;
            yvga = (k < 4) ? py[k] : IDLE_Y;
            bg_color = (k >= 1 && k <= 4) ? pbg[k-1] : 3'b111;
            glyph_pixel = (k >= 2 && k <= 5) ? pgp[k-2] : 3'b111;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; xvga = IDLE_X; yvga = IDLE_Y; digits = 16'h0000; overlay_en = 1'b0;
        blink_mask = 4'b0000; suppress_lz = 1'b0; bg_color = 3'b000; glyph_pixel = 3'b000;
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_priority();
        test_leading_zero();
        test_blink();
        test_disabled();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
